// File: rtl/ad9911_pkg.sv
// Shared constants, register map and helpers for the AD9911 serial register writer.
package ad9911_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned FRAME_W = 40;

  // AD9911 register map (channel-common and channel registers)
  localparam logic [ADDR_W-1:0] CSR   = 8'h00;
  localparam logic [ADDR_W-1:0] FR1   = 8'h01;
  localparam logic [ADDR_W-1:0] FR2   = 8'h02;
  localparam logic [ADDR_W-1:0] CFR   = 8'h03;
  localparam logic [ADDR_W-1:0] CTW0  = 8'h04;
  localparam logic [ADDR_W-1:0] CPOW0 = 8'h05;
  localparam logic [ADDR_W-1:0] ACR   = 8'h06;
  localparam logic [ADDR_W-1:0] LSRR  = 8'h07;
  localparam logic [ADDR_W-1:0] RDW   = 8'h08;
  localparam logic [ADDR_W-1:0] FDW   = 8'h09;
  localparam logic [ADDR_W-1:0] CTW1  = 8'h0A;

  localparam logic [ADDR_W-1:0] ADDR_MAX = 8'h18;

  // Instruction byte MSB: 0 selects a register write
  localparam logic INSTR_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_CS_HOLD,
    ST_IOUP,
    ST_ERR_WAIT
  } state_e;

  // Payload length in bits of the register at addr
  function automatic logic [LEN_W-1:0] reg_len(input logic [ADDR_W-1:0] addr);
    case (addr)
      CSR:                   reg_len = LEN_W'(8);
      FR1, CFR, ACR:         reg_len = LEN_W'(24);
      FR2, CPOW0, LSRR:      reg_len = LEN_W'(16);
      CTW0, RDW, FDW, CTW1:  reg_len = LEN_W'(32);
      default:               reg_len = LEN_W'(32);
    endcase
  endfunction

endpackage

// File: rtl/ad9911_sclk_gen.sv
// Half-period tick counter: flags the cycles on which SCLK should rise or fall.
module ad9911_sclk_gen
  import ad9911_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  input  logic sclk_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q;
  logic             tick_c;

  assign tick_c   = run_i && (cnt_q == CNT_W'(SCLK_HALF - 1));
  assign rise_c_o = tick_c && !sclk_i;
  assign fall_c_o = tick_c && sclk_i;

  // Count cycles within the current half-period; restart when idle or on a tick
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (!run_i || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ad9911_serial_writer.sv
// Responder side of the TR/BUSY write handshake: serialises one AD9911 register write
// (instruction byte + payload, MSB first) and strobes IO_UPDATE afterwards.
module ad9911_serial_writer
  import ad9911_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 1,
  parameter int unsigned IOUP_W    = 2
) (
  input  logic              CLOCK_10M,
  input  logic              RESET_N,
  input  logic              TR,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA,
  input  logic              MRSET,
  output logic              BUSY,
  output logic              ERR,
  output logic              SCLK,
  output logic              SDIO,
  output logic              CS_N,
  output logic              IO_UPDATE,
  output logic              MASTER_RESET
);

  localparam int unsigned CNT_W = 4;

  state_e             state_q;
  logic               armed_q;
  logic               busy_q;
  logic               err_q;
  logic               sclk_q;
  logic               sdio_q;
  logic               cs_n_q;
  logic               ioup_q;
  logic               mreset_q;
  logic [FRAME_W-1:0] sr_q;
  logic [LEN_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   wait_q;

  logic               accept_d;
  logic               bad_addr_d;
  logic [LEN_W-1:0]   len_d;
  logic [DATA_W-1:0]  data_al_d;
  logic [FRAME_W-1:0] frame_d;
  logic               run_c;
  logic               rise_c;
  logic               fall_c;

  // Request decode and left-aligned frame assembly from the live ADDR/DATA inputs
  always_comb begin
    accept_d   = (state_q == ST_IDLE) && TR && armed_q && !MRSET;
    bad_addr_d = ADDR > ADDR_MAX;
    len_d      = reg_len(ADDR);
    data_al_d  = DATA << (LEN_W'(DATA_W) - len_d);
    frame_d    = {INSTR_WRITE, 2'b00, ADDR[4:0], data_al_d};
    run_c      = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT_HI) ||
                 (state_q == ST_SHIFT_LO) || (state_q == ST_CS_HOLD);
  end

  ad9911_sclk_gen #(
    .SCLK_HALF (SCLK_HALF)
  ) u_sclk_gen (
    .clk_i    (CLOCK_10M),
    .rst_n_i  (RESET_N),
    .run_i    (run_c),
    .sclk_i   (sclk_q),
    .rise_c_o (rise_c),
    .fall_c_o (fall_c)
  );

  // Transfer FSM with registered serial-port outputs; MRSET aborts any transfer
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      sclk_q    <= 1'b0;
      sdio_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      ioup_q    <= 1'b0;
      mreset_q  <= 1'b1;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      wait_q    <= '0;
    end else begin
      mreset_q <= MRSET;
      if (!TR) begin
        armed_q <= 1'b1;
      end
      if (MRSET) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        sclk_q  <= 1'b0;
        sdio_q  <= 1'b0;
        cs_n_q  <= 1'b1;
        ioup_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept_d) begin
              armed_q <= 1'b0;
              busy_q  <= 1'b1;
              if (bad_addr_d) begin
                err_q   <= 1'b1;
                wait_q  <= CNT_W'(1);
                state_q <= ST_ERR_WAIT;
              end else begin
                cs_n_q    <= 1'b0;
                sdio_q    <= frame_d[FRAME_W-1];
                sr_q      <= frame_d << 1;
                bit_cnt_q <= len_d + LEN_W'(7);
                state_q   <= ST_CS_SETUP;
              end
            end
          end
          ST_CS_SETUP, ST_SHIFT_LO: begin
            if (rise_c) begin
              sclk_q  <= 1'b1;
              state_q <= ST_SHIFT_HI;
            end
          end
          ST_SHIFT_HI: begin
            if (fall_c) begin
              sclk_q <= 1'b0;
              if (bit_cnt_q == '0) begin
                state_q <= ST_CS_HOLD;
              end else begin
                sdio_q    <= sr_q[FRAME_W-1];
                sr_q      <= sr_q << 1;
                bit_cnt_q <= bit_cnt_q - LEN_W'(1);
                state_q   <= ST_SHIFT_LO;
              end
            end
          end
          ST_CS_HOLD: begin
            if (rise_c) begin
              cs_n_q  <= 1'b1;
              sdio_q  <= 1'b0;
              ioup_q  <= 1'b1;
              wait_q  <= CNT_W'(IOUP_W - 1);
              state_q <= ST_IOUP;
            end
          end
          ST_IOUP: begin
            if (wait_q == '0) begin
              ioup_q  <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              wait_q <= wait_q - CNT_W'(1);
            end
          end
          ST_ERR_WAIT: begin
            if (wait_q == '0) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              wait_q <= wait_q - CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign BUSY         = busy_q;
  assign ERR          = err_q;
  assign SCLK         = sclk_q;
  assign SDIO         = sdio_q;
  assign CS_N         = cs_n_q;
  assign IO_UPDATE    = ioup_q;
  assign MASTER_RESET = mreset_q;

endmodule

// File: tb/tb_ad9911_serial_writer.sv
// Bench for ad9911_serial_writer: two instances (SCLK_HALF=1/IOUP_W=2 and SCLK_HALF=3/IOUP_W=3)
// driven in parallel; a bus monitor decodes frames and a spec-level model predicts them.
module tb_ad9911_serial_writer;

  localparam int H0 = 1;
  localparam int H1 = 3;
  localparam int IW0 = 2;
  localparam int IW1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tr;
  logic [7:0]  addr;
  logic [31:0] data;
  logic        mrset;

  logic [1:0] busy, err, sclk, sdio, cs_n, iou, mres;

  ad9911_serial_writer #(.SCLK_HALF(H0), .IOUP_W(IW0)) dut0 (
    .CLOCK_10M(clk), .RESET_N(rst_n), .TR(tr), .ADDR(addr), .DATA(data), .MRSET(mrset),
    .BUSY(busy[0]), .ERR(err[0]), .SCLK(sclk[0]), .SDIO(sdio[0]), .CS_N(cs_n[0]),
    .IO_UPDATE(iou[0]), .MASTER_RESET(mres[0])
  );

  ad9911_serial_writer #(.SCLK_HALF(H1), .IOUP_W(IW1)) dut1 (
    .CLOCK_10M(clk), .RESET_N(rst_n), .TR(tr), .ADDR(addr), .DATA(data), .MRSET(mrset),
    .BUSY(busy[1]), .ERR(err[1]), .SCLK(sclk[1]), .SDIO(sdio[1]), .CS_N(cs_n[1]),
    .IO_UPDATE(iou[1]), .MASTER_RESET(mres[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic err_exp = 1'b0;

  function automatic int hh(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int iw(input int i);
    return (i == 0) ? IW0 : IW1;
  endfunction

  // Payload length from the AD9911 register map
  function automatic int ref_len(input int a);
    if (a == 0) return 8;
    if (a == 1 || a == 3 || a == 6) return 24;
    if (a == 2 || a == 5 || a == 7) return 16;
    return 32;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Cumulative bus monitor, sampled on the falling clock edge
  int          cyc = 0;
  int          nbits[2]     = '{0, 0};
  int          busy_cyc[2]  = '{0, 0};
  int          iou_cyc[2]   = '{0, 0};
  int          cs_fall[2]   = '{0, 0};
  int          cs_iou[2]    = '{0, 0};
  int          gap_bad[2]   = '{0, 0};
  int          sdio_bad[2]  = '{0, 0};
  int          last_rise[2] = '{-1, -1};
  logic [63:0] shreg[2]     = '{64'd0, 64'd0};
  logic [1:0]  sclk_p = 2'b00, csn_p = 2'b11, sdio_p = 2'b00, iou_p = 2'b00;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sclk[i] === 1'b1 && sclk_p[i] === 1'b0 && cs_n[i] === 1'b0) begin
        shreg[i] = {shreg[i][62:0], sdio[i]};
        nbits[i] = nbits[i] + 1;
        if (last_rise[i] >= 0 && (cyc - last_rise[i]) != 2 * hh(i)) gap_bad[i] = gap_bad[i] + 1;
        last_rise[i] = cyc;
      end
      if (cs_n[i] !== 1'b0) last_rise[i] = -1;
      if (busy[i] === 1'b1) busy_cyc[i] = busy_cyc[i] + 1;
      if (iou[i] === 1'b1) iou_cyc[i] = iou_cyc[i] + 1;
      if (cs_n[i] === 1'b1 && csn_p[i] === 1'b0 && iou[i] === 1'b1 && iou_p[i] === 1'b0)
        cs_iou[i] = cs_iou[i] + 1;
      if (cs_n[i] === 1'b0 && csn_p[i] === 1'b1) cs_fall[i] = cs_fall[i] + 1;
      if (sdio[i] !== sdio_p[i] && !(sclk_p[i] === 1'b1 && sclk[i] === 1'b0) && cs_n[i] === csn_p[i])
        sdio_bad[i] = sdio_bad[i] + 1;
    end
    sclk_p = sclk;
    csn_p  = cs_n;
    sdio_p = sdio;
    iou_p  = iou;
    cyc    = cyc + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string tag, input logic mres_exp);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_i%0d_busy", tag, i), 64'(busy[i]), 64'd0);
      check_eq($sformatf("%s_i%0d_err", tag, i), 64'(err[i]), 64'(err_exp));
      check_eq($sformatf("%s_i%0d_sclk", tag, i), 64'(sclk[i]), 64'd0);
      check_eq($sformatf("%s_i%0d_sdio", tag, i), 64'(sdio[i]), 64'd0);
      check_eq($sformatf("%s_i%0d_csn", tag, i), 64'(cs_n[i]), 64'd1);
      check_eq($sformatf("%s_i%0d_ioup", tag, i), 64'(iou[i]), 64'd0);
      check_eq($sformatf("%s_i%0d_mreset", tag, i), 64'(mres[i]), 64'(mres_exp));
    end
  endtask

  // One handshake: raise TR, drop it once BUSY is seen (unless hold), then check the frame
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input bit hold);
    int s_nb[2], s_busy[2], s_iou[2], s_csf[2], s_csi[2], s_gap[2], s_sd[2];
    bit ok;
    bit bad;
    int n, nn, eb;
    logic [63:0] ef, mask;
    for (int i = 0; i < 2; i++) begin
      s_nb[i] = nbits[i];   s_busy[i] = busy_cyc[i]; s_iou[i] = iou_cyc[i];
      s_csf[i] = cs_fall[i]; s_csi[i] = cs_iou[i];   s_gap[i] = gap_bad[i];
      s_sd[i] = sdio_bad[i];
    end
    bad  = (a > 8'h18);
    addr = a;
    data = d;
    tr   = 1'b1;
    ok   = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      cycles(1);
      ok = (busy[0] === 1'b1) && (busy[1] === 1'b1);
    end
    check_eq($sformatf("a%02h_accept", a), 64'(ok), 64'd1);
    addr = 8'($urandom);
    data = $urandom;
    if (!hold) tr = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      cycles(1);
      ok = (busy[0] === 1'b0) && (busy[1] === 1'b0);
    end
    check_eq($sformatf("a%02h_done", a), 64'(ok), 64'd1);
    cycles(1);
    if (bad) err_exp = 1'b1;
    n    = bad ? 0 : ref_len(int'(a));
    nn   = bad ? 0 : 8 + n;
    mask = (64'd1 << nn) - 64'd1;
    ef   = (64'(a & 8'h1F) << n) | (64'(d) & ((64'd1 << n) - 64'd1));
    for (int i = 0; i < 2; i++) begin
      eb = bad ? 2 : 2 * hh(i) * nn + hh(i) + iw(i);
      check_eq($sformatf("i%0d_a%02h_nbits", i, a), 64'(nbits[i] - s_nb[i]), 64'(nn));
      if (!bad) check_eq($sformatf("i%0d_a%02h_frame", i, a), shreg[i] & mask, ef);
      check_eq($sformatf("i%0d_a%02h_busy_cycles", i, a), 64'(busy_cyc[i] - s_busy[i]), 64'(eb));
      check_eq($sformatf("i%0d_a%02h_ioup_cycles", i, a), 64'(iou_cyc[i] - s_iou[i]), 64'(bad ? 0 : iw(i)));
      check_eq($sformatf("i%0d_a%02h_cs_fall", i, a), 64'(cs_fall[i] - s_csf[i]), 64'(bad ? 0 : 1));
      check_eq($sformatf("i%0d_a%02h_cs_ioup_same_edge", i, a), 64'(cs_iou[i] - s_csi[i]), 64'(bad ? 0 : 1));
      check_eq($sformatf("i%0d_a%02h_sclk_period", i, a), 64'(gap_bad[i] - s_gap[i]), 64'd0);
      check_eq($sformatf("i%0d_a%02h_sdio_timing", i, a), 64'(sdio_bad[i] - s_sd[i]), 64'd0);
      check_eq($sformatf("i%0d_a%02h_err", i, a), 64'(err[i]), 64'(err_exp));
      check_eq($sformatf("i%0d_a%02h_csn_idle", i, a), 64'(cs_n[i]), 64'd1);
    end
  endtask

  initial begin
    int sb;
    int s0;
    bit ok;
    rst_n = 1'b0; tr = 1'b0; mrset = 1'b0; addr = '0; data = '0;
    cycles(3);
    check_idle("reset", 1'b1);
    rst_n = 1'b1;
    cycles(3);
    check_idle("post_reset", 1'b0);

    // Directed frames
    do_write(8'h04, 32'h16147AE1, 1'b0);
    do_write(8'h00, 32'h00000020, 1'b0);

    // Full controller sequence over addresses 0..10
    for (int a = 0; a <= 10; a++) do_write(8'(a), $urandom, 1'b0);

    // TR held high after a frame must not start another
    do_write(8'h04, $urandom, 1'b1);
    sb = busy_cyc[0] + busy_cyc[1];
    cycles(60);
    check_eq("held_tr_no_retrigger", 64'(busy_cyc[0] + busy_cyc[1] - sb), 64'd0);
    tr = 1'b0;
    cycles(2);

    // Invalid addresses and sticky ERR
    do_write(8'h1F, $urandom, 1'b0);
    do_write(8'h19, $urandom, 1'b0);
    do_write(8'h06, $urandom, 1'b0);

    // Randomized writes, including some invalid addresses
    repeat (12) do_write(8'($urandom_range(0, 8'h1C)), $urandom, 1'b0);

    // MRSET abort mid-frame at bit 10 of the fast instance
    s0   = nbits[0];
    addr = 8'h04;
    data = $urandom;
    tr   = 1'b1;
    ok   = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      cycles(1);
      ok = (nbits[0] - s0) >= 10;
    end
    check_eq("abort_reached_bit10", 64'(ok), 64'd1);
    tr    = 1'b0;
    mrset = 1'b1;
    cycles(1);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("abort_i%0d_csn", i), 64'(cs_n[i]), 64'd1);
      check_eq($sformatf("abort_i%0d_busy", i), 64'(busy[i]), 64'd0);
      check_eq($sformatf("abort_i%0d_mreset", i), 64'(mres[i]), 64'd1);
      check_eq($sformatf("abort_i%0d_sclk", i), 64'(sclk[i]), 64'd0);
      check_eq($sformatf("abort_i%0d_ioup", i), 64'(iou[i]), 64'd0);
      check_eq($sformatf("abort_i%0d_err", i), 64'(err[i]), 64'(err_exp));
    end
    cycles(3);
    mrset = 1'b0;
    cycles(2);
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("abort_i%0d_mreset_release", i), 64'(mres[i]), 64'd0);
    do_write(8'h09, $urandom, 1'b0);

    // Asynchronous reset mid-frame
    addr = 8'h08;
    data = $urandom;
    tr   = 1'b1;
    cycles(20);
    rst_n = 1'b0;
    #1;
    err_exp = 1'b0;
    check_idle("async_reset", 1'b1);
    tr = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    do_write(8'h03, $urandom, 1'b0);
    do_write(8'h00, $urandom, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
